// File: rtl/vga_fetch_responder.sv
// Two-entry pixel-word buffer (current + sequential prefetch) in front of a Wishbone read master.
// Hits answer VGA combinationally; misses, preloads and prefetches go out through the VGA bus slot.
module vga_fetch_responder #(
  parameter logic [31:0] BASE_WORD = 32'h3E80,
  parameter int unsigned FB_WORDS  = 384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_req,
  input  logic [31:0] vga_word_addr,
  input  logic [3:0]  vga_sel,
  input  logic [1:0]  vga_state,
  output logic [31:0] vga_data,
  output logic        vga_busy,
  output logic        bus_req,
  input  logic        grant,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam logic [31:0] LastWord = BASE_WORD + 32'(FB_WORDS) - 32'd1;

  typedef enum logic [1:0] {StIdle, StArb, StBus} state_e;

  state_e      state_q, state_d;
  logic        cur_valid_q, cur_valid_d, nxt_valid_q, nxt_valid_d;
  logic [31:0] cur_tag_q, cur_tag_d, cur_data_q, cur_data_d;
  logic [31:0] nxt_tag_q, nxt_tag_d, nxt_data_q, nxt_data_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [3:0]  fetch_sel_q, fetch_sel_d;
  logic        fetch_is_demand_q, fetch_is_demand_d;
  logic        pf_pend_q, pf_pend_d, preload_pend_q, preload_pend_d;
  logic        discard_q, discard_d;
  logic        cyc_q;
  logic [1:0]  vga_state_q;

  logic        in_win, lookup, cur_hit, nxt_hit, miss, active, preload_evt;
  logic [31:0] pf_addr;

  assign in_win      = (vga_word_addr >= BASE_WORD) && (vga_word_addr <= LastWord);
  assign lookup      = vga_req && in_win;
  assign cur_hit     = lookup && cur_valid_q && (cur_tag_q == vga_word_addr);
  assign nxt_hit     = lookup && !cur_hit && nxt_valid_q && (nxt_tag_q == vga_word_addr);
  assign miss        = lookup && !cur_hit && !nxt_hit;
  assign active      = (vga_state != 2'd0);
  assign preload_evt = (vga_state == 2'd1) && (vga_state_q != 2'd1);
  assign pf_addr     = (cur_tag_q == LastWord) ? BASE_WORD : cur_tag_q + 32'd1;

  assign vga_busy = miss;
  assign vga_data = cur_hit ? cur_data_q : (nxt_hit ? nxt_data_q : 32'd0);
  assign bus_req  = (state_q != StIdle);
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = 1'b0;
  assign wb_adr_o = fetch_addr_q << 2;
  assign wb_sel_o = fetch_sel_q;

  always_comb begin
    state_d           = state_q;
    cur_valid_d       = cur_valid_q;
    cur_tag_d         = cur_tag_q;
    cur_data_d        = cur_data_q;
    nxt_valid_d       = nxt_valid_q;
    nxt_tag_d         = nxt_tag_q;
    nxt_data_d        = nxt_data_q;
    fetch_addr_d      = fetch_addr_q;
    fetch_sel_d       = fetch_sel_q;
    fetch_is_demand_d = fetch_is_demand_q;
    pf_pend_d         = pf_pend_q;
    preload_pend_d    = preload_pend_q;
    discard_d         = discard_q;

    unique case (state_q)
      StIdle: begin
        if (miss && active) begin
          state_d           = StArb;
          fetch_addr_d      = vga_word_addr;
          fetch_sel_d       = vga_sel;
          fetch_is_demand_d = 1'b1;
        end else if (preload_pend_q) begin
          state_d           = StArb;
          fetch_addr_d      = BASE_WORD;
          fetch_sel_d       = 4'hF;
          fetch_is_demand_d = 1'b0;
          preload_pend_d    = 1'b0;
        end else if (pf_pend_q && cur_valid_q && active) begin
          state_d           = StArb;
          fetch_addr_d      = pf_addr;
          fetch_sel_d       = 4'hF;
          fetch_is_demand_d = 1'b0;
          pf_pend_d         = 1'b0;
        end
      end
      StArb: begin
        // A waiting prefetch is retargeted to the demand word before it reaches the bus.
        if (miss && active && !fetch_is_demand_q) begin
          fetch_addr_d      = vga_word_addr;
          fetch_sel_d       = vga_sel;
          fetch_is_demand_d = 1'b1;
        end
        if (grant) state_d = StBus;
      end
      StBus: begin
        if (wb_ack_i) begin
          state_d   = StIdle;
          discard_d = 1'b0;
          if (!discard_q) begin
            if (fetch_is_demand_q || !cur_valid_q) begin
              cur_valid_d = 1'b1;
              cur_tag_d   = fetch_addr_q;
              cur_data_d  = wb_dat_i;
              pf_pend_d   = 1'b1;
            end else begin
              nxt_valid_d = 1'b1;
              nxt_tag_d   = fetch_addr_q;
              nxt_data_d  = wb_dat_i;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (nxt_hit) begin
      cur_valid_d = 1'b1;
      cur_tag_d   = nxt_tag_q;
      cur_data_d  = nxt_data_q;
      nxt_valid_d = 1'b0;
      pf_pend_d   = 1'b1;
    end

    // Preload invalidation overrides any fill landing on the same edge.
    if (preload_evt) begin
      cur_valid_d    = 1'b0;
      nxt_valid_d    = 1'b0;
      pf_pend_d      = 1'b0;
      preload_pend_d = 1'b1;
      discard_d      = (state_d != StIdle);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= StIdle;
      cur_valid_q       <= 1'b0;
      cur_tag_q         <= 32'd0;
      cur_data_q        <= 32'd0;
      nxt_valid_q       <= 1'b0;
      nxt_tag_q         <= 32'd0;
      nxt_data_q        <= 32'd0;
      fetch_addr_q      <= 32'd0;
      fetch_sel_q       <= 4'd0;
      fetch_is_demand_q <= 1'b0;
      pf_pend_q         <= 1'b0;
      preload_pend_q    <= 1'b0;
      discard_q         <= 1'b0;
      cyc_q             <= 1'b0;
      vga_state_q       <= 2'd0;
    end else begin
      state_q           <= state_d;
      cur_valid_q       <= cur_valid_d;
      cur_tag_q         <= cur_tag_d;
      cur_data_q        <= cur_data_d;
      nxt_valid_q       <= nxt_valid_d;
      nxt_tag_q         <= nxt_tag_d;
      nxt_data_q        <= nxt_data_d;
      fetch_addr_q      <= fetch_addr_d;
      fetch_sel_q       <= fetch_sel_d;
      fetch_is_demand_q <= fetch_is_demand_d;
      pf_pend_q         <= pf_pend_d;
      preload_pend_q    <= preload_pend_d;
      discard_q         <= discard_d;
      cyc_q             <= (state_d == StBus);
      vga_state_q       <= vga_state;
    end
  end

endmodule

// File: tb/tb_vga_fetch_responder.sv
// Directed and randomized checks of vga_fetch_responder against a memory-image model:
// any non-busy in-window read must return the SRAM word for that address.
module tb_vga_fetch_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        vga_req;
  logic [31:0] vga_word_addr;
  logic [3:0]  vga_sel;
  logic [1:0]  vga_state;
  logic [31:0] vga_data;
  logic        vga_busy;
  logic        bus_req;
  logic        grant;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned ack_wait    = 0;
  int unsigned wait_cnt    = 0;
  logic        slave_en    = 1'b1;
  logic [31:0] adr_log[$];
  logic [3:0]  sel_log[$];

  int          n, busy_run;
  logic        saw_cyc, holding;
  logic [31:0] prev_addr;
  int unsigned r;

  always #5 clk = ~clk;

  vga_fetch_responder dut (
    .clk           (clk),
    .rst           (rst),
    .vga_req       (vga_req),
    .vga_word_addr (vga_word_addr),
    .vga_sel       (vga_sel),
    .vga_state     (vga_state),
    .vga_data      (vga_data),
    .vga_busy      (vga_busy),
    .bus_req       (bus_req),
    .grant         (grant),
    .wb_cyc_o      (wb_cyc_o),
    .wb_stb_o      (wb_stb_o),
    .wb_we_o       (wb_we_o),
    .wb_adr_o      (wb_adr_o),
    .wb_sel_o      (wb_sel_o),
    .wb_dat_i      (wb_dat_i),
    .wb_ack_i      (wb_ack_i)
  );

  // SRAM image: every word holds a fixed function of its own word address.
  function automatic logic [31:0] word_data(input logic [31:0] w);
    return {w[15:0] ^ 16'h5A5A, ~w[15:0]};
  endfunction

  function automatic logic in_window(input logic [31:0] w);
    return (w >= 32'h3E80) && (w <= 32'h3FFF);
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < adr_log.size()) return adr_log[i];
    return 32'hDEAD_DEAD;
  endfunction

  assign wb_dat_i = word_data(wb_adr_o >> 2);
  assign wb_ack_i = slave_en && wb_cyc_o && wb_stb_o && (wait_cnt >= ack_wait);

  always @(posedge clk) begin
    if (wb_cyc_o && wb_stb_o && !wb_ack_i) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (wb_ack_i) begin
      adr_log.push_back(wb_adr_o);
      sel_log.push_back(wb_sel_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(negedge clk);
    #1;
  endtask

  task automatic wait_cyc(input string tag);
    for (int k = 0; k < 20 && !wb_cyc_o; k++) step(1);
    check(tag, 32'(wb_cyc_o), 32'd1);
  endtask

  task automatic wait_not_busy(input string tag);
    for (int k = 0; k < 30 && vga_busy; k++) step(1);
    check(tag, 32'(vga_busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; vga_req = 1'b0; vga_word_addr = 32'd0; vga_sel = 4'hF;
    vga_state = 2'd0; grant = 1'b1;
    step(2);
    check("rst_data", vga_data, 32'd0);
    check("rst_busy", 32'(vga_busy), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_stb", 32'(wb_stb_o), 32'd0);
    check("rst_we", 32'(wb_we_o), 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_sel", 32'(wb_sel_o), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Reset while a bus cycle is open.
    vga_state = 2'd2; slave_en = 1'b0;
    vga_req = 1'b1; vga_word_addr = 32'h3E80; vga_sel = 4'h3;
    step(1);
    wait_cyc("cyc_before_rst");
    check("demand_adr", wb_adr_o, 32'h0000_FA00);
    check("demand_sel", 32'(wb_sel_o), 32'h3);
    @(negedge clk); rst = 1'b1; vga_req = 1'b0; vga_state = 2'd0;
    step(2);
    rst = 1'b0;
    check("cyc_after_rst", 32'(wb_cyc_o), 32'd0);
    check("busy_after_rst", 32'(vga_busy), 32'd0);
    check("data_after_rst", vga_data, 32'd0);
    vga_req = 1'b1; vga_word_addr = 32'h3E80;
    #1 check("miss_after_rst", 32'(vga_busy), 32'd1);
    vga_req = 1'b0; slave_en = 1'b1; vga_sel = 4'hF;

    // Preload and sequential hits.
    @(negedge clk); adr_log.delete(); sel_log.delete(); vga_state = 2'd1;
    step(15);
    check("preload_adr0", log_at(0), 32'h0000_FA00);
    check("preload_adr1", log_at(1), 32'h0000_FA04);
    vga_req = 1'b1; vga_word_addr = 32'h3E80;
    #1 check("hit0_busy", 32'(vga_busy), 32'd0);
    check("hit0_data", vga_data, word_data(32'h3E80));
    @(negedge clk); vga_word_addr = 32'h3E81;
    #1 check("hit1_busy", 32'(vga_busy), 32'd0);
    check("hit1_data", vga_data, word_data(32'h3E81));
    @(negedge clk); vga_req = 1'b0;
    step(10);

    // Cold miss with a two-wait slave.
    @(negedge clk); vga_state = 2'd2; ack_wait = 2; adr_log.delete(); sel_log.delete();
    vga_req = 1'b1; vga_word_addr = 32'h3E90; vga_sel = 4'h1;
    #1 n = 0;
    for (int k = 0; k < 30 && vga_busy; k++) begin
      n++;
      step(1);
    end
    check("miss_busy_cycles", 32'(n), 32'd5);
    check("miss_data", vga_data, word_data(32'h3E90));
    step(10);
    check("miss_fetch_adr", log_at(0), 32'h0000_FA40);
    check("prefetch_adr", log_at(1), 32'h0000_FA44);
    check("prefetch_sel", 32'((sel_log.size() > 1) ? sel_log[1] : 4'h0), 32'hF);
    @(negedge clk); vga_req = 1'b0; vga_sel = 4'hF;

    // Prefetch wrap from the last framebuffer word.
    @(negedge clk); ack_wait = 0; adr_log.delete();
    vga_req = 1'b1; vga_word_addr = 32'h3FFF;
    #1 wait_not_busy("wrap_fill");
    check("wrap_data", vga_data, word_data(32'h3FFF));
    step(10);
    check("wrap_prefetch_adr", log_at(1), 32'h0000_FA00);
    @(negedge clk); vga_req = 1'b0;

    // Grant dropped in BUS, then withheld in ARB.
    @(negedge clk); ack_wait = 4; vga_req = 1'b1; vga_word_addr = 32'h3EA0;
    #1 wait_cyc("gl_cyc_rise");
    @(negedge clk); grant = 1'b0;
    step(2);
    check("gl_cyc_held", 32'(wb_cyc_o), 32'd1);
    check("gl_stb_held", 32'(wb_stb_o), 32'd1);
    for (int k = 0; k < 10 && wb_cyc_o; k++) step(1);
    check("gl_cyc_fell", 32'(wb_cyc_o), 32'd0);
    check("gl_data", vga_data, word_data(32'h3EA0));
    step(2);
    check("arb_bus_req", 32'(bus_req), 32'd1);
    check("arb_no_stb", 32'(wb_stb_o), 32'd0);
    grant = 1'b1; ack_wait = 0;
    step(10);
    vga_req = 1'b0;

    // Out-of-window request.
    step(2);
    vga_req = 1'b1; vga_word_addr = 32'h0000_0010;
    #1 check("oow_busy", 32'(vga_busy), 32'd0);
    check("oow_data", vga_data, 32'd0);
    saw_cyc = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      saw_cyc = saw_cyc | wb_cyc_o;
    end
    check("oow_no_bus", 32'(saw_cyc), 32'd0);
    vga_req = 1'b0;

    // Preload on the same edge as an ack.
    @(negedge clk); ack_wait = 3; vga_req = 1'b1; vga_word_addr = 32'h3EC0;
    #1 wait_cyc("col_cyc_rise");
    vga_state = 2'd0;
    for (int k = 0; k < 10 && !wb_ack_i; k++) step(1);
    check("col_ack_seen", 32'(wb_ack_i), 32'd1);
    vga_state = 2'd1;
    step(1);
    check("col_cur_invalid", 32'(vga_busy), 32'd1);
    vga_word_addr = 32'h3E80;
    #1 check("col_base_invalid", 32'(vga_busy), 32'd1);
    vga_req = 1'b0;
    @(negedge clk); vga_state = 2'd2; ack_wait = 0;
    step(20);

    // Randomized reads against the memory-image model.
    holding = 1'b0; busy_run = 0; prev_addr = 32'h3E80; vga_sel = 4'hF;
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      grant = ($urandom_range(0, 3) != 0);
      ack_wait = $urandom_range(0, 2);
      if (!holding) begin
        vga_req = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 9);
        if (r == 0) vga_word_addr = $urandom_range(0, 32'h3000);
        else if (r <= 2) vga_word_addr = 32'h3E80 + $urandom_range(0, 383);
        else vga_word_addr = (prev_addr == 32'h3FFF) ? 32'h3E80 : prev_addr + 32'd1;
        if (vga_req && in_window(vga_word_addr)) prev_addr = vga_word_addr;
      end
      #1;
      check("rnd_we", 32'(wb_we_o), 32'd0);
      check("rnd_stb_eq_cyc", 32'(wb_stb_o), 32'(wb_cyc_o));
      if (!vga_req || !in_window(vga_word_addr)) begin
        check("rnd_idle_busy", 32'(vga_busy), 32'd0);
        check("rnd_idle_data", vga_data, 32'd0);
      end else if (vga_busy) begin
        holding = 1'b1;
        busy_run++;
        if (busy_run > 40) begin
          check("rnd_busy_bound", 32'(busy_run), 32'd40);
          break;
        end
      end else begin
        check("rnd_data", vga_data, word_data(vga_word_addr));
        holding = 1'b0;
        busy_run = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_fetch_responder.md
# vga_fetch_responder

- Serves the VGA scan-out block's pixel-word reads: it answers `data_en` / `word_address_dest` with `SRAM_data_in` / `SRAM_busy`.
- Fetches the words as a Wishbone read master toward SRAM, using the VGA slot granted by the IO controller (client 1).
- Holds a two-entry word buffer (current + sequential prefetch) so that runs of sequential pixel words hit with zero latency.
- Sits between VGA_out and the IO controller's Wishbone mux.

## Interface
Parameters:
- `BASE_WORD`, default `32'h3E80`: word address of the first framebuffer word.
- `FB_WORDS`, default `384`: framebuffer length in words; the valid window is `BASE_WORD .. BASE_WORD+FB_WORDS-1`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `vga_req` in 1: VGA read request (VGA `data_en`).
- `vga_word_addr` in 32: requested word address.
- `vga_sel` in 4: byte select from VGA; forwarded on demand fetches.
- `vga_state` in 2: 0 = inactive, 1 = about to be active, 2 = active.
- `vga_data` out 32: pixel word returned to VGA.
- `vga_busy` out 1: 1 = `vga_data` is not valid this cycle.
- `bus_req` out 1: request for the Wishbone slot to the IO controller.
- `grant` in 1: IO controller has selected the VGA client.
- `wb_cyc_o` out 1, `wb_stb_o` out 1: Wishbone cycle / strobe.
- `wb_we_o` out 1: tied to 0.
- `wb_adr_o` out 32: byte address, `word << 2`.
- `wb_sel_o` out 4: byte select; `4'hF` on prefetch fetches.
- `wb_dat_i` in 32: read data from SRAM.
- `wb_ack_i` in 1: Wishbone acknowledge.

## Operation
- Buffer entries are CUR and NXT. Each holds {valid, tag[31:0], data[31:0]}.
- Lookup is combinational and only applies when `vga_req` = 1 and the address is in the window:
  - CUR hit: `vga_busy` = 0, `vga_data` = CUR.data.
  - NXT hit: `vga_busy` = 0, `vga_data` = NXT.data. On the next edge NXT moves to CUR, NXT is invalidated, and a prefetch of tag+1 is scheduled.
  - Miss: `vga_busy` = 1 and a demand fetch is scheduled.
- Out-of-window address with `vga_req` = 1: `vga_busy` = 0, `vga_data` = 0, no bus cycle.
- `vga_req` = 0: `vga_busy` = 0, `vga_data` = 0.
- Prefetch address = CUR.tag+1. When CUR.tag = `BASE_WORD+FB_WORDS-1`, it wraps to `BASE_WORD`.
- Preload: the cycle `vga_state` becomes 1, both entries are invalidated and a prefetch of `BASE_WORD` into CUR is scheduled.
- Fill targets:
  - A demand fill writes CUR and then schedules a prefetch of tag+1 into NXT.
  - A prefetch fill writes NXT, or CUR if CUR is invalid.
- Priority when choosing a fetch: demand > preload > prefetch. No new fetch is issued while `vga_state` = 0, except the preload.

FSM states:
- IDLE: leaves to ARB when any fetch is scheduled. On that transition it latches `fetch_addr`, `fetch_sel` and `fetch_is_demand`.
- ARB: `bus_req` = 1. Moves to BUS on the first cycle `grant` = 1.
- BUS: `bus_req` = 1, `wb_cyc_o` = `wb_stb_o` = 1, `wb_adr_o` = `fetch_addr<<2`. On `wb_ack_i` = 1 it captures `wb_dat_i` into the target entry and returns to IDLE.

Boundary conditions:
- `grant` dropping while in BUS is ignored: the cycle is held until ack, with no abort.
- A demand miss arriving while a prefetch is in ARB: the scheduled address is replaced by the demand address.
- A demand miss arriving while a prefetch is in BUS: the prefetch completes first.
  - If its tag equals the demand address, the request hits on the next cycle and no extra fetch is made.
  - Otherwise the demand fetch is issued next.
- `vga_req` falling during a demand fetch: the fetch still completes and fills CUR.
- Preload (`vga_state` becoming 1) on the same edge as an ack: the preload invalidation wins and the acked data is discarded.
- `rst` in any state: on the next edge FSM = IDLE and all entries are invalid.

## Timing
- Reset values:
  - `vga_data` = 0, `vga_busy` = 0, `bus_req` = 0.
  - `wb_cyc_o` = 0, `wb_stb_o` = 0, `wb_we_o` = 0.
  - `wb_adr_o` = 0, `wb_sel_o` = 0.
- Hit latency: 0 cycles, because lookup is combinational from the `vga_req` / `vga_word_addr` inputs.
- Miss with `grant` already 1: request at cycle N.
  - N+1: ARB. N+2: BUS, `wb_cyc_o` = `wb_stb_o` = 1.
  - `vga_busy` stays 1 through the ack cycle A.
  - A+1: `wb_cyc_o` = 0; CUR is valid, so `vga_busy` = 0.
  - Minimum miss latency with a zero-wait slave: 3 cycles of `busy`.
- Wishbone signals are all registered. `cyc` and `stb` rise and fall together, and `wb_adr_o` / `wb_sel_o` are stable for the whole BUS state.
- Back-to-back fetches must return to IDLE for at least one cycle between them.

## Test plan
- Reset: assert `rst` for 2 cycles while `wb_cyc_o` = 1 → cycle after: `wb_cyc_o` = 0, `vga_busy` = 0, `vga_data` = 0; next request for `32'h3E80` misses.
- Preload + sequential: `vga_state` 0→1 with `grant` = 1 and zero-wait slave (`wb_dat_i` = address data) → reads at byte addresses `32'hFA00`, then `32'hFA04`. Then `vga_req` for `32'h3E80` then `32'h3E81` → `vga_busy` = 0 on both, data matches.
- Cold miss: `vga_req` for `32'h3E90` with buffer invalid and `grant` = 1, slave acks 2 cycles after strobe → `vga_busy` = 1 for 5 cycles, then data returned; prefetch of `32'hFA44` follows.
- Wrap: CUR.tag = `32'h3FFF` (last word) → prefetch `wb_adr_o` = `32'hFA00`.
- Grant loss: `grant` dropped during BUS → `wb_cyc_o` held until ack; with `grant` = 0 in ARB → `bus_req` = 1, no strobe.
- Out-of-range and collision: request `32'h0000_0010` → `vga_busy` = 0, `vga_data` = 0, no bus cycle. `vga_state`→1 on the same edge as an ack → both entries invalid afterwards.
